// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter
//   Shares one combinational register-file read port between two requesters
//   (A and B) using round-robin arbitration. The read result lands in a
//   one-entry response buffer one cycle after the grant.
//
// Ports
//   clock, ctrl_reset                     : clock, synchronous active-high reset
//   req_a_valid/req_a_reg/req_a_ready     : requester A read handshake
//   req_b_valid/req_b_reg/req_b_ready     : requester B read handshake
//   ctrl_readReg / data_readReg           : regfile read address / read data
//   ctrl_writeEnable/ctrl_writeReg/
//   data_writeReg                         : snoop of the regfile write port
//   rsp_valid/rsp_id/rsp_reg/rsp_data/
//   rsp_ready                             : response handshake (rsp_id 0=A, 1=B)
//
// Configuration
//   REGFILE_ARB_BYPASS_EN : when defined, a same-cycle write to the granted
//                           (nonzero) register is forwarded into the response.
//                           When undefined, the pre-write read data is used.

module regfile_read_arbiter (
    input  logic        clock,
    input  logic        ctrl_reset,

    input  logic        req_a_valid,
    input  logic [4:0]  req_a_reg,
    output logic        req_a_ready,

    input  logic        req_b_valid,
    input  logic [4:0]  req_b_reg,
    output logic        req_b_ready,

    output logic [4:0]  ctrl_readReg,
    input  logic [31:0] data_readReg,

    input  logic        ctrl_writeEnable,
    input  logic [4:0]  ctrl_writeReg,
    input  logic [31:0] data_writeReg,

    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [4:0]  rsp_reg,
    output logic [31:0] rsp_data,
    input  logic        rsp_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        last_q;            // last granted requester: 0=A, 1=B
    logic        rsp_id_q;
    logic [4:0]  rsp_reg_q;
    logic [31:0] rsp_data_q;

    logic        slot_free;
    logic        grant;
    logic        grant_b;
    logic [4:0]  grant_reg;
    logic [31:0] grant_data;

    // The buffer can accept a new entry when it is empty or is being drained
    // in this same cycle, which gives back-to-back responses.
    assign slot_free = (state_q == EMPTY) || rsp_ready;

    always_comb begin
        grant      = 1'b0;
        grant_b    = 1'b0;
        grant_reg  = '0;
        grant_data = '0;
        state_d    = state_q;

        if (!ctrl_reset && slot_free && (req_a_valid || req_b_valid)) begin
            grant = 1'b1;
            // B wins when it is the only requester, or on a tie when A was
            // granted last.
            grant_b   = req_b_valid && (!req_a_valid || !last_q);
            grant_reg = grant_b ? req_b_reg : req_a_reg;
        end

        if (grant_reg != 5'd0) begin
`ifdef REGFILE_ARB_BYPASS_EN
            if (ctrl_writeEnable && (ctrl_writeReg == grant_reg))
                grant_data = data_writeReg;
            else
                grant_data = data_readReg;
`else
            grant_data = data_readReg;
`endif
        end

        case (state_q)
            EMPTY:   if (grant) state_d = FULL;
            FULL:    if (rsp_ready && !grant) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

`ifndef REGFILE_ARB_BYPASS_EN
    // Write-snoop ports have no function in this build.
    logic unused_snoop;
    assign unused_snoop = ^{ctrl_writeEnable, ctrl_writeReg, data_writeReg};
`endif

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            state_q    <= EMPTY;
            last_q     <= 1'b1;
            rsp_id_q   <= 1'b0;
            rsp_reg_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                last_q     <= grant_b;
                rsp_id_q   <= grant_b;
                rsp_reg_q  <= grant_reg;
                rsp_data_q <= grant_data;
            end
        end
    end

    assign req_a_ready  = grant && !grant_b;
    assign req_b_ready  = grant &&  grant_b;
    assign ctrl_readReg = grant_reg;

    assign rsp_valid = (state_q == FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_reg   = rsp_reg_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: doc/regfile_read_arbiter.md
REGFILE_READ_ARBITER -- requirements
Module: regfile_read_arbiter

Interface
REQ-001 SHALL provide ports: clock  in  1  sole clock, all state on rising edge.
REQ-002 SHALL provide ports: ctrl_reset  in  1  synchronous reset, active-high.
REQ-003 SHALL provide ports: req_a_valid  in  1 / req_a_reg  in  5 / req_a_ready  out  1; requester A read handshake.
REQ-004 SHALL provide ports: req_b_valid  in  1 / req_b_reg  in  5 / req_b_ready  out  1; requester B read handshake.
REQ-005 SHALL provide ports: ctrl_readReg  out  5  shared regfile read address; data_readReg  in  32  regfile read data, combinational from ctrl_readReg.
REQ-006 SHALL provide ports: ctrl_writeEnable  in  1 / ctrl_writeReg  in  5 / data_writeReg  in  32; snoop of the regfile write port.
REQ-007 SHALL provide ports: rsp_valid  out  1 / rsp_id  out  1 (0=A, 1=B) / rsp_reg  out  5 / rsp_data  out  32 / rsp_ready  in  1; response handshake.

Function
REQ-008 SHALL arbitrate the single regfile read port between A and B, at most one grant per cycle.
REQ-009 SHALL hold a one-entry response buffer; FSM states EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-010 SHALL define slot_free = EMPTY, or FULL with rsp_ready=1 in the same cycle.
REQ-011 SHALL grant only when slot_free and at least one request is valid; req_x_ready=1 only for the granted requester, combinational in the grant cycle.
REQ-012 SHALL use round-robin priority: if A and B are both valid, grant the requester not granted last; a single valid requester always wins.
REQ-013 SHALL update the last-grant pointer only on a grant; the pointer resets to B, so A wins the first tie.
REQ-014 SHALL drive ctrl_readReg = granted requester's reg in the grant cycle, else 5'd0.
REQ-015 SHALL capture the response on the grant edge: rsp_data, rsp_id, rsp_reg; rsp_valid=1 the next cycle (1-cycle latency).
REQ-016 SHALL force rsp_data=0 when the granted reg is 0, regardless of data_readReg or bypass.
REQ-017 SHALL move FULL->EMPTY on rsp_ready with no new grant; FULL->FULL on rsp_ready plus a grant (back-to-back, one response per cycle); FULL stays FULL with outputs held stable on rsp_ready=0.
REQ-018 SHALL move EMPTY->FULL on grant; EMPTY stays EMPTY otherwise.
REQ-019 SHALL, while FULL and rsp_ready=0, deassert both req_x_ready and ignore new valids without losing them (requesters hold valid).
REQ-020 SHALL bound wait: a continuously valid requester is granted within 2 grants.

Reset
REQ-021 SHALL, on clock edge with ctrl_reset=1: state EMPTY, rsp_valid=0, rsp_id=0, rsp_reg=0, rsp_data=0, last-grant pointer=B.
REQ-022 SHALL hold req_a_ready=req_b_ready=0 and ctrl_readReg=0 while ctrl_reset=1.
REQ-023 SHALL discard a buffered response on reset mid-operation; no grant occurs in a reset cycle.

Configuration
REQ-024 SHALL honour macro REGFILE_ARB_BYPASS_EN.
REQ-025 SHALL, with REGFILE_ARB_BYPASS_EN defined, capture data_writeReg instead of data_readReg when ctrl_writeEnable=1, ctrl_writeReg equals the granted reg, and the reg is nonzero.
REQ-026 SHALL, without REGFILE_ARB_BYPASS_EN, always capture data_readReg (pre-write value); the write-snoop ports are unused.

Verification
REQ-027 SHALL test: A only, reg 5, regfile r5=0x1234 -> next cycle rsp_valid=1, rsp_id=0, rsp_reg=5, rsp_data=0x1234.
REQ-028 SHALL test: A and B both valid for 4 cycles after reset, rsp_ready=1 -> grants A, B, A, B; a response every cycle.
REQ-029 SHALL test: rsp_ready=0 with response buffered for 3 cycles -> rsp_* stable, req_a_ready=req_b_ready=0; on rsp_ready=1, next grant in the same cycle.
REQ-030 SHALL test: read reg 0 with data_readReg=0xFFFFFFFF -> rsp_data=0.
REQ-031 SHALL test: grant reg 7 with write reg 7 = 0xCAFE same cycle (r7 old=0x11) -> rsp_data=0xCAFE with macro, 0x11 without.
REQ-032 SHALL test: ctrl_reset=1 while FULL -> next cycle rsp_valid=0, and the first tie after reset grants A.
